// File: rtl/fw_dut_emu_pkg.sv
// Shared types and constants for the FW->DUT configuration chain emulator.
package fw_dut_emu_pkg;
    localparam int CFG_BITS_DEF = 768;
    localparam int BIT_CNT_W    = 16;
    localparam int LOAD_CNT_W   = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } emu_state_t;
endpackage

// File: rtl/fw_edge_det.sv
// Input sampler: optional 2-flop synchronizer (FW_DUT_EMU_SYNC_EN), then sample
// and previous-value registers producing the sampled level and its rising edge.
module fw_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_lvl,
    output logic o_rise
);
    logic w_in;
    logic r_smp;
    logic r_prv;

`ifdef FW_DUT_EMU_SYNC_EN
    logic r_s1;
    logic r_s2;
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end
    assign w_in = r_s2;
`else
    assign w_in = i_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_smp <= 1'b0;
            r_prv <= 1'b0;
        end else begin
            r_smp <= w_in;
            r_prv <= r_smp;
        end
    end

    assign o_lvl  = r_smp;
    assign o_rise = r_smp & ~r_prv;
endmodule

// File: rtl/fw_dut_cfg_emulator.sv
// DUT-side stand-in for the FW config chain: shift register, shadow capture,
// counters and frame-length check. FW_DUT_EMU_SYNC_EN adds input synchronizers.
module fw_dut_cfg_emulator
    import fw_dut_emu_pkg::*;
#(
    parameter int CFG_BITS = CFG_BITS_DEF
) (
    input  logic                  fw_clk_100,
    input  logic                  fw_rst,
    input  logic                  fw_config_clk,
    input  logic                  fw_reset_not,
    input  logic                  fw_config_in,
    input  logic                  fw_config_load,
    output logic                  fw_config_out,
    output logic [CFG_BITS-1:0]   emu_cfg_shadow,
    output logic [BIT_CNT_W-1:0]  emu_bit_count,
    output logic [LOAD_CNT_W-1:0] emu_load_count,
    output logic                  emu_frame_done,
    output logic                  emu_len_err,
    output logic                  emu_busy
);
    logic w_clk_lvl, w_clk_rise;
    logic w_load_lvl, w_load_rise;
    logic w_din, w_din_unused_rise;
    logic w_rstn, w_rstn_unused_rise;
    logic w_clr;
    logic w_len_bad;

    logic [CFG_BITS-1:0]   r_sr;
    logic [CFG_BITS-1:0]   r_shadow;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [LOAD_CNT_W-1:0] r_load_cnt;
    logic                  r_frame_done;
    logic                  r_len_err;
    emu_state_t            r_state, w_next;

    fw_edge_det u_ed_clk  (.i_clk(fw_clk_100), .i_rst(fw_rst), .i_d(fw_config_clk),
                           .o_lvl(w_clk_lvl),  .o_rise(w_clk_rise));
    fw_edge_det u_ed_load (.i_clk(fw_clk_100), .i_rst(fw_rst), .i_d(fw_config_load),
                           .o_lvl(w_load_lvl), .o_rise(w_load_rise));
    fw_edge_det u_ed_din  (.i_clk(fw_clk_100), .i_rst(fw_rst), .i_d(fw_config_in),
                           .o_lvl(w_din),      .o_rise(w_din_unused_rise));
    fw_edge_det u_ed_rstn (.i_clk(fw_clk_100), .i_rst(fw_rst), .i_d(fw_reset_not),
                           .o_lvl(w_rstn),     .o_rise(w_rstn_unused_rise));

    logic w_unused;
    assign w_unused  = ^{w_clk_lvl, w_load_lvl, w_din_unused_rise, w_rstn_unused_rise};

    assign w_clr     = fw_rst | ~w_rstn;
    assign w_len_bad = (r_bit_cnt != BIT_CNT_W'(CFG_BITS));

    // Shadow captures the pre-shift chain; a coincident shift becomes bit 1 of the next frame.
    always_ff @(posedge fw_clk_100) begin
        if (w_clr) begin
            r_sr         <= '0;
            r_shadow     <= '0;
            r_bit_cnt    <= '0;
            r_load_cnt   <= '0;
            r_frame_done <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_frame_done <= w_load_rise;
            if (w_clk_rise)
                r_sr <= {r_sr[CFG_BITS-2:0], w_din};
            if (w_load_rise) begin
                r_shadow   <= r_sr;
                r_load_cnt <= r_load_cnt + 1'b1;
                if (w_len_bad)
                    r_len_err <= 1'b1;
                r_bit_cnt  <= w_clk_rise ? BIT_CNT_W'(1) : '0;
            end else if (w_clk_rise && (r_bit_cnt != '1)) begin
                r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge fw_clk_100) begin
        if (w_clr) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_clk_rise && !w_load_rise) w_next = SHIFT;
            SHIFT: if (w_load_rise && !w_clk_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign fw_config_out  = r_sr[CFG_BITS-1];
    assign emu_cfg_shadow = r_shadow;
    assign emu_bit_count  = r_bit_cnt;
    assign emu_load_count = r_load_cnt;
    assign emu_frame_done = r_frame_done;
    assign emu_len_err    = r_len_err;
    assign emu_busy       = (r_state == SHIFT);
endmodule

// File: tb/tb_fw_dut_cfg_emulator.sv
// Directed bench for fw_dut_cfg_emulator with an 8-bit chain.
module tb_fw_dut_cfg_emulator;
    localparam int CB = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_clk = 1'b0;
    logic          rstn = 1'b1;
    logic          din = 1'b0;
    logic          load = 1'b0;
    logic          dout;
    logic [CB-1:0] shadow;
    logic [15:0]   bit_cnt;
    logic [7:0]    load_cnt;
    logic          fdone;
    logic          len_err;
    logic          busy;

    int vectors = 0;
    int errs    = 0;
    int fd_cnt  = 0;

    fw_dut_cfg_emulator #(.CFG_BITS(CB)) dut (
        .fw_clk_100    (clk),
        .fw_rst        (rst),
        .fw_config_clk (cfg_clk),
        .fw_reset_not  (rstn),
        .fw_config_in  (din),
        .fw_config_load(load),
        .fw_config_out (dout),
        .emu_cfg_shadow(shadow),
        .emu_bit_count (bit_cnt),
        .emu_load_count(load_cnt),
        .emu_frame_done(fdone),
        .emu_len_err   (len_err),
        .emu_busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (fdone) fd_cnt <= fd_cnt + 1;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic shift_bit(input logic b);
        din = b;
        cfg_clk = 1'b1;
        cyc(2);
        cfg_clk = 1'b0;
        cyc(2);
    endtask

    task automatic do_load();
        load = 1'b1;
        cyc(2);
        load = 1'b0;
        cyc(2);
    endtask

    logic [15:0] pat;
    logic [7:0]  pat8;
    int          fd0;

    initial begin
        // Reset with random inputs
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            cfg_clk = 1'($urandom); din = 1'($urandom);
            load = 1'($urandom); rstn = 1'($urandom);
            cyc(1);
        end
        chk("rst_out",    {31'd0, dout}, 0);
        chk("rst_shadow", {24'd0, shadow}, 0);
        chk("rst_bitcnt", {16'd0, bit_cnt}, 0);
        chk("rst_ldcnt",  {24'd0, load_cnt}, 0);
        chk("rst_flags",  {29'd0, fdone, len_err, busy}, 0);
        cfg_clk = 0; din = 0; load = 0; rstn = 1;
        rst = 0;
        cyc(4);

        // Nominal frame 8'hA5
        pat8 = 8'hA5;
        for (int i = 7; i >= 0; i--) shift_bit(pat8[i]);
        chk("nom_bitcnt", {16'd0, bit_cnt}, 8);
        chk("nom_busy",   {31'd0, busy}, 1);
        chk("nom_out",    {31'd0, dout}, 1);
        fd0 = fd_cnt;
        do_load();
        chk("nom_shadow", {24'd0, shadow}, 32'hA5);
        chk("nom_bitcnt0",{16'd0, bit_cnt}, 0);
        chk("nom_ldcnt",  {24'd0, load_cnt}, 1);
        chk("nom_fdpulse", fd_cnt - fd0, 1);
        chk("nom_lenerr", {31'd0, len_err}, 0);
        chk("nom_idle",   {31'd0, busy}, 0);

        // Overlong frame 16'h1234: tail carries 8'h12 during shifts 9-16
        pat = 16'h1234;
        pat8 = 8'h12;
        for (int i = 15; i >= 0; i--) begin
            shift_bit(pat[i]);
            if (i >= 1 && i <= 8)
                chk($sformatf("long_out%0d", 8 - i), {31'd0, dout}, {31'd0, pat8[i-1]});
        end
        chk("long_bitcnt", {16'd0, bit_cnt}, 16);
        do_load();
        chk("long_shadow", {24'd0, shadow}, 32'h34);
        chk("long_lenerr", {31'd0, len_err}, 1);
        chk("long_ldcnt",  {24'd0, load_cnt}, 2);

        // fw_reset_not clears state
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
        chk("rn_pre_cnt", {16'd0, bit_cnt}, 3);
        rstn = 0;
        cyc(3);
        chk("rn_out",    {31'd0, dout}, 0);
        chk("rn_bitcnt", {16'd0, bit_cnt}, 0);
        chk("rn_shadow", {24'd0, shadow}, 0);
        chk("rn_lenerr", {31'd0, len_err}, 0);
        chk("rn_ldcnt",  {24'd0, load_cnt}, 0);
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        chk("rn_hold_cnt",  {16'd0, bit_cnt}, 0);
        chk("rn_hold_busy", {31'd0, busy}, 0);
        chk("rn_hold_out",  {31'd0, dout}, 0);
        rstn = 1;
        cyc(3);

        // Coincident clk_rise and load_rise
        pat8 = 8'hF0;
        for (int i = 7; i >= 0; i--) shift_bit(pat8[i]);
        din = 1; cfg_clk = 1; load = 1;
        cyc(2);
        cfg_clk = 0; load = 0;
        cyc(2);
        chk("same_shadow", {24'd0, shadow}, 32'hF0);
        chk("same_bitcnt", {16'd0, bit_cnt}, 1);
        chk("same_busy",   {31'd0, busy}, 1);
        chk("same_lenerr", {31'd0, len_err}, 0);
        pat8 = 8'hE1;
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("same_sr%0d", j), {31'd0, dout}, {31'd0, pat8[7-j]});
            shift_bit(1'b0);
        end

        // 256 zero-bit loads wrap the load counter
        rst = 1; cyc(2); rst = 0; cyc(3);
        fd0 = fd_cnt;
        for (int i = 0; i < 255; i++) do_load();
        chk("wrap_255",   {24'd0, load_cnt}, 255);
        do_load();
        chk("wrap_0",     {24'd0, load_cnt}, 0);
        chk("wrap_lenerr",{31'd0, len_err}, 1);
        chk("wrap_fd",    fd_cnt - fd0, 256);
        chk("wrap_shadow",{24'd0, shadow}, 0);
        chk("wrap_busy",  {31'd0, busy}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fw_dut_cfg_emulator.md
# fw_dut_cfg_emulator

Synthesizable stand-in for the DUT end of the FW→DUT configuration chain. It sits where the ASIC would connect to a FW IP's config pins, in the fw_clk_100 domain. It shifts in fw_config_in on each rising edge of fw_config_clk, returns the chain tail on fw_config_out, and captures the chain into a shadow register on fw_config_load. It also flags frame-length errors, so FW config sequences can be loop-back tested on the board and in simulation without silicon.

## Interface
- CFG_BITS, 768: configuration chain length in bits (≥2).
- fw_clk_100  in  1  FW clock, 100 MHz; all logic on rising edge.
- fw_rst  in  1  reset, synchronous, active-high.
- fw_config_clk  in  1  chain shift clock from the FW IP, treated as data and edge-detected.
- fw_reset_not  in  1  DUT reset from the FW IP, active-low level.
- fw_config_in  in  1  serial config data, MSB first.
- fw_config_load  in  1  chain-to-shadow load strobe, rising-edge detected.
- fw_config_out  out  CFG_BITS-1 tail of the shift register, returned to the FW IP.
- emu_cfg_shadow  out  CFG_BITS  last loaded configuration.
- emu_bit_count  out  16  shifts since the last load; saturates at 16'hFFFF.
- emu_load_count  out  8  number of loads; wraps 255→0.
- emu_frame_done  out  1  one-cycle pulse per load.
- emu_len_err  out  1  sticky: a load occurred with emu_bit_count ≠ CFG_BITS.
- emu_busy  out  1  FSM in SHIFT.

## Operation
- Inputs fw_config_clk and fw_config_load each pass through a sample register plus a previous-value register.
  - clk_rise = sampled & ~previous; load_rise likewise.
  - fw_config_in is sampled in the same stage as fw_config_clk.
- Clear condition is fw_rst=1 or sampled fw_reset_not=0. While clear is active:
  - the shift register, emu_cfg_shadow, all counts and emu_len_err go to 0, and the FSM goes to IDLE;
  - edges are ignored.
- On clk_rise: shift register ← {sr[CFG_BITS-2:0], sampled fw_config_in}, and emu_bit_count increments with saturation.
- fw_config_out = sr[CFG_BITS-1], driven directly from the register.
- On load_rise:
  - emu_cfg_shadow ← sr, using the value before any same-cycle shift;
  - emu_load_count increments;
  - emu_frame_done pulses;
  - if the pre-update emu_bit_count ≠ CFG_BITS, emu_len_err ← 1;
  - emu_bit_count ← 0, or ← 1 when clk_rise occurs in the same cycle.
- The FSM has two states:
  - IDLE → SHIFT on clk_rise without load_rise;
  - SHIFT → IDLE on load_rise, unless clk_rise occurs in the same cycle, in which case it stays in SHIFT;
  - IDLE + load_rise (zero-bit frame) loads the shadow and sets emu_len_err, since 0 ≠ CFG_BITS.
- emu_len_err clears only on the clear condition.

## Timing
- Reset values: every output is 0. fw_config_out is 0 because the shift register is cleared.
- Let edge E be the fw_clk_100 edge at which fw_config_clk is first sampled high.
  - clk_rise is asserted in the cycle after E.
  - The shift register, fw_config_out and emu_bit_count update at E+1.
  - Input-to-fw_config_out latency is 2 edges.
- Load path: fw_config_load is first sampled high at edge L. emu_cfg_shadow, emu_load_count and emu_len_err update at L+1, and emu_frame_done is high for the cycle following L+1.
- fw_config_clk and fw_config_load each require high and low phases of ≥1 fw_clk_100 cycle. A phase shorter than one cycle may be missed; this is not detected.
- fw_reset_not takes effect with the same sample latency.

## Configuration
- FW_DUT_EMU_SYNC_EN defined: a 2-flop synchronizer is inserted ahead of the sample register on fw_config_clk, fw_config_in, fw_config_load and fw_reset_not. All latencies grow by 2 edges; inputs may be asynchronous to fw_clk_100.
- Not defined: inputs must be synchronous to fw_clk_100, and the latencies in Timing apply exactly.

## Structure
- Package fw_dut_emu_pkg holds:
  - the emu_state_t enum {IDLE, SHIFT};
  - BIT_CNT_W=16 and LOAD_CNT_W=8;
  - the default CFG_BITS constant.
- Sub-module fw_edge_det (one instance per edged input) holds the optional synchronizer plus the sample/previous registers, and outputs the sampled level and rise.
- Top level: shift register, shadow, counters, FSM.

## Test plan
- Reset: fw_rst high 2 cycles with random inputs → all outputs 0, emu_busy 0.
- Nominal frame, CFG_BITS=8: shift 8'hA5 MSB first, then load → emu_cfg_shadow=8'hA5, emu_bit_count 8→0, emu_load_count=1, one emu_frame_done pulse, emu_len_err=0.
- Overlong frame, CFG_BITS=8: shift 16'h1234 → fw_config_out emits the bits of 8'h12 MSB first during shifts 9–16; after load, emu_cfg_shadow=8'h34 and emu_len_err=1.
- fw_reset_not low after 3 shifts → shift register, emu_bit_count and emu_cfg_shadow=0; 5 edges while low leave emu_bit_count=0.
- Same-cycle clk_rise and load_rise with sr=8'hF0, fw_config_in=1 → emu_cfg_shadow=8'hF0, sr=8'hE1, emu_bit_count=1, emu_busy=1.
- 256 loads → emu_load_count wraps to 0; emu_len_err=1 (zero-bit frames).
